// File: rtl/mux_n_1_scan.sv
// Registered N:1 multiplexer with a manual select mode and a round-robin scan mode.
// y, ch and tick are all registered; the FSM state is exposed on a debug output.
module mux_n_1_scan #(
    parameter int WIDTH = 4,
    parameter int CH    = 4,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   i,
    input  logic [SW-1:0]         s,
    input  logic                  mode,
    input  logic                  en,
    output logic [WIDTH-1:0]      y,
    output logic [SW-1:0]         ch,
    output logic                  tick,
    output logic [1:0]            state
);

    localparam int CW = $clog2(DWELL) + 1;
    localparam logic [SW:0]   CH_LIMIT = (SW+1)'(CH);
    localparam logic [SW-1:0] CH_LAST  = SW'(CH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        MAN  = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            st;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     ch_next;
    logic [CW-1:0]     cnt_next;
    logic              tick_next;
    logic [WIDTH-1:0]  chan [CH];

    for (genvar k = 0; k < CH; k++) begin : g_chan
        assign chan[k] = i[k*WIDTH +: WIDTH];
    end

    assign state = st;

    // Next index/count for an enabled edge; HOLD is handled in the register block.
    always_comb begin
        ch_next   = ch;
        cnt_next  = '0;
        tick_next = 1'b0;
        if (mode) begin
            if (cnt == CNT_LAST) begin
                ch_next   = (ch == CH_LAST) ? '0 : ch + 1'b1;
                tick_next = 1'b1;
            end else begin
                cnt_next  = cnt + 1'b1;
            end
        end else if ({1'b0, s} < CH_LIMIT) begin
            // Out-of-range selects keep the channel already on display.
            ch_next = s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= MAN;
            y    <= '0;
            ch   <= '0;
            tick <= 1'b0;
            cnt  <= '0;
        end else if (!en) begin
            st   <= HOLD;
            tick <= 1'b0;
        end else begin
            st   <= mode ? SCAN : MAN;
            ch   <= ch_next;
            y    <= chan[ch_next];
            cnt  <= cnt_next;
            tick <= tick_next;
        end
    end

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Bench for mux_n_1_scan: a CH=4/DWELL=4 instance and a CH=3/DWELL=1 instance
// checked every cycle against a position-in-rotation model plus literal expectations.
module tb_mux_n_1_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  = 1'b1;
    logic        en   = 1'b1;
    logic        mode = 1'b1;
    logic [1:0]  s    = 2'd0;
    logic [15:0] ia   = 16'hDCBA;
    logic [11:0] ib   = 12'hCBA;

    logic [3:0]  ya, yb;
    logic [1:0]  cha, chb;
    logic        ticka, tickb;
    logic [1:0]  sta, stb;

    mux_n_1_scan #(.WIDTH(4), .CH(4), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .i(ia), .s(s), .mode(mode), .en(en),
        .y(ya), .ch(cha), .tick(ticka), .state(sta)
    );

    mux_n_1_scan #(.WIDTH(4), .CH(3), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .i(ib), .s(s), .mode(mode), .en(en),
        .y(yb), .ch(chb), .tick(tickb), .state(stb)
    );

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in scan, the displayed channel is the entry channel advanced by
    // floor(enabled scan edges / DWELL), modulo CH. Manual mode re-bases it.
    int m_y[2], m_ch[2], m_tick[2], m_state[2], base[2], elapsed[2];

    function automatic int slice(input logic [15:0] v, input int k);
        return int'((v >> (k*4)) & 16'h000F);
    endfunction

    task automatic model_step(input int k, input int chn, input int dw,
                              input logic [15:0] iv);
        if (rst) begin
            m_y[k] = 0; m_ch[k] = 0; m_tick[k] = 0; m_state[k] = 0;
            base[k] = 0; elapsed[k] = 0;
        end else if (!en) begin
            m_tick[k] = 0; m_state[k] = 2;
        end else if (!mode) begin
            if (int'(s) < chn) m_ch[k] = int'(s);
            base[k] = m_ch[k]; elapsed[k] = 0;
            m_tick[k] = 0; m_state[k] = 0;
            m_y[k] = slice(iv, m_ch[k]);
        end else begin
            elapsed[k]++;
            m_ch[k] = (base[k] + elapsed[k] / dw) % chn;
            m_tick[k] = (elapsed[k] % dw == 0) ? 1 : 0;
            m_state[k] = 1;
            m_y[k] = slice(iv, m_ch[k]);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 4, 4, ia);
        model_step(1, 3, 1, {4'h0, ib});
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("a_y", int'(ya), m_y[0]);
            check("a_ch", int'(cha), m_ch[0]);
            check("a_tick", int'(ticka), m_tick[0]);
            check("a_state", int'(sta), m_state[0]);
            check("b_y", int'(yb), m_y[1]);
            check("b_ch", int'(chb), m_ch[1]);
            check("b_tick", int'(tickb), m_tick[1]);
            check("b_state", int'(stb), m_state[1]);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int ticks;

    initial begin
        // Reset for two edges with scan requested.
        edges(2);
        check("rst_y", int'(ya), 0);
        check("rst_ch", int'(cha), 0);
        check("rst_tick", int'(ticka), 0);
        check("rst_state", int'(sta), 0);

        rst = 1'b0; mode = 1'b0; s = 2'd2;
        edges(1);
        check("man_s2_y", int'(ya), 4'hC);
        check("man_s2_ch", int'(cha), 2);

        s = 2'd3;
        edges(1);
        check("man_s3_y", int'(ya), 4'hD);
        check("man_s3_ch", int'(cha), 3);
        check("b_oor_keep", int'(chb), 2);

        ia[15:12] = 4'h5;
        edges(1);
        check("live_y", int'(ya), 4'h5);
        ia = 16'hDCBA;

        s = 2'd0;
        edges(1);
        check("man_s0_y", int'(ya), 4'hA);

        // Scan 19 edges from ch0: ch0 x4 (incl. current), 1x4, 2x4, 3x4, 0x4.
        mode = 1'b1;
        ticks = 0;
        for (int n = 1; n <= 19; n++) begin
            edges(1);
            if (ticka) ticks++;
            if (n == 3) check("scan_n3_ch", int'(cha), 0);
            if (n == 4) begin
                check("scan_n4_ch", int'(cha), 1);
                check("scan_n4_y", int'(ya), 4'hB);
                check("scan_n4_tick", int'(ticka), 1);
            end
            if (n == 12) check("scan_n12_y", int'(ya), 4'hD);
            if (n == 16) begin
                check("scan_wrap_ch", int'(cha), 0);
                check("scan_wrap_y", int'(ya), 4'hA);
            end
        end
        check("scan_tick_count", ticks, 4);

        // Reach ch1 with cnt=2, then freeze for five edges.
        edges(3);
        check("pre_freeze_ch", int'(cha), 1);
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            edges(1);
            check("frz_y", int'(ya), 4'hB);
            check("frz_ch", int'(cha), 1);
            check("frz_tick", int'(ticka), 0);
            check("frz_state", int'(sta), 2);
        end
        en = 1'b1;
        edges(1);
        check("resume1_ch", int'(cha), 1);
        edges(1);
        check("resume2_ch", int'(cha), 2);
        check("resume2_tick", int'(ticka), 1);

        // Scan to manual mid-rotation.
        mode = 1'b0; s = 2'd0;
        edges(1);
        check("sw_man_ch", int'(cha), 0);
        check("sw_man_y", int'(ya), 4'hA);

        // Back to scan, reset when cnt reaches 3.
        mode = 1'b1;
        edges(3);
        rst = 1'b1;
        edges(1);
        check("midrst_y", int'(ya), 0);
        check("midrst_ch", int'(cha), 0);
        check("midrst_tick", int'(ticka), 0);
        check("midrst_state", int'(sta), 0);
        rst = 1'b0;

        // Odd CH, DWELL=1: manual ch1, out-of-range keeps it, then scan every edge.
        mode = 1'b0; s = 2'd1;
        edges(1);
        check("b_man_ch", int'(chb), 1);
        s = 2'd3;
        edges(1);
        check("b_oor_ch", int'(chb), 1);
        check("b_oor_y", int'(yb), 4'hB);
        mode = 1'b1;
        edges(1);
        check("b_scan1_ch", int'(chb), 2);
        check("b_scan1_tick", int'(tickb), 1);
        edges(1);
        check("b_scan2_ch", int'(chb), 0);
        check("b_scan2_y", int'(yb), 4'hA);
        edges(1);
        check("b_scan3_ch", int'(chb), 1);
        check("b_scan3_tick", int'(tickb), 1);

        edges(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
